// File: rtl/mux_sel_sequencer.sv
// Sweeps a 4:1 mux select through 0..3, holding each value HOLD_CYCLES cycles.
// Optional capture of the fed-back mux output is enabled by macro SEQ_CAPTURE_EN.
module mux_sel_sequencer #(
    parameter int HOLD_CYCLES = 10
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic [3:0] DATA_IN,
    input  logic       Y_IN,
    output logic       A,
    output logic       B,
    output logic       D0,
    output logic       D1,
    output logic       D2,
    output logic       D3,
    output logic [3:0] RESULT,
    output logic       BUSY,
    output logic       DONE
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] hold_cnt;
    logic [1:0] sel;
    logic [3:0] data_q;
    logic [3:0] result_q;
    logic       last_hold;
    logic       accept;

    assign last_hold = (hold_cnt == HOLD_LAST);
    assign accept    = (state == IDLE) && START;

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: leave RUN once sel=3 has finished its hold period.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (START) state_nxt = RUN;
            RUN:  if (last_hold && (sel == 2'd3)) state_nxt = FIN;
            FIN:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Select/hold counter and latched data word; sel wraps 3->0 entering FIN.
    always_ff @(posedge CLK) begin
        if (RST) begin
            hold_cnt <= '0;
            sel      <= '0;
            data_q   <= '0;
        end else if (accept) begin
            hold_cnt <= '0;
            sel      <= '0;
            data_q   <= DATA_IN;
        end else if (state == RUN) begin
            if (last_hold) begin
                hold_cnt <= '0;
                sel      <= sel + 2'd1;
            end else begin
                hold_cnt <= hold_cnt + 8'd1;
            end
        end
    end

`ifdef SEQ_CAPTURE_EN
    // Capture Y_IN into RESULT[3-sel] on the final hold cycle of each select.
    always_ff @(posedge CLK) begin
        if (RST) begin
            result_q <= '0;
        end else if (accept) begin
            result_q <= '0;
        end else if ((state == RUN) && last_hold) begin
            result_q[~sel] <= Y_IN;
        end
    end
`else
    logic unused_y_in;
    assign unused_y_in = Y_IN;
    assign result_q    = 4'b0000;
`endif

    assign A      = sel[1];
    assign B      = sel[0];
    assign D0     = data_q[3];
    assign D1     = data_q[2];
    assign D2     = data_q[1];
    assign D3     = data_q[0];
    assign RESULT = result_q;
    assign BUSY   = (state == RUN);
    assign DONE   = (state == FIN);

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Bench: two sequencers (HOLD 10 and HOLD 1) on shared stimulus, ideal mux loop,
// arithmetic sweep-timing model plus a DONE-driven scoreboard.
module tb_mux_sel_sequencer;

    localparam int H0 = 10;
    localparam int H1 = 1;

`ifdef SEQ_CAPTURE_EN
    localparam bit CAP = 1'b1;
`else
    localparam bit CAP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] din = 4'h0;

    logic       a0, b0, d00, d01, d02, d03, y0, bz0, dn0;
    logic       a1, b1, d10, d11, d12, d13, y1, bz1, dn1;
    logic [3:0] r0, r1;

    always #5 clk = ~clk;

    function automatic logic mux4(input logic [1:0] s, input logic [3:0] dw);
        return dw[3 - s];
    endfunction

    assign y0 = mux4({a0, b0}, {d00, d01, d02, d03});
    assign y1 = mux4({a1, b1}, {d10, d11, d12, d13});

    mux_sel_sequencer #(.HOLD_CYCLES(H0)) dut0 (
        .CLK(clk), .RST(rst), .START(start), .DATA_IN(din), .Y_IN(y0),
        .A(a0), .B(b0), .D0(d00), .D1(d01), .D2(d02), .D3(d03),
        .RESULT(r0), .BUSY(bz0), .DONE(dn0)
    );

    mux_sel_sequencer #(.HOLD_CYCLES(H1)) dut1 (
        .CLK(clk), .RST(rst), .START(start), .DATA_IN(din), .Y_IN(y1),
        .A(a1), .B(b1), .D0(d10), .D1(d11), .D2(d12), .D3(d13),
        .RESULT(r1), .BUSY(bz1), .DONE(dn1)
    );

    int         vecs = 0;
    int         errs = 0;
    int         cyc = 0;
    bit         mon_en = 1'b0;
    int         hc[2] = '{H0, H1};
    int         s_at[2] = '{-1, -1};
    int         free_at[2] = '{0, 0};
    logic [3:0] lat[2] = '{4'h0, 4'h0};
    logic [3:0] q0[$];
    logic [3:0] q1[$];

    // Reference model: a sweep accepted at edge e runs 4H cycles, FIN, then
    // the next START can be sampled at edge e+4H+2.
    task automatic model_step();
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                s_at[i]    = -1;
                free_at[i] = 0;
                lat[i]     = 4'h0;
                if (i == 0) q0.delete(); else q1.delete();
            end else if (start && cyc >= free_at[i]) begin
                s_at[i]    = cyc;
                free_at[i] = cyc + 4 * hc[i] + 2;
                lat[i]     = din;
                if (i == 0) q0.push_back(din); else q1.push_back(din);
            end
        end
        if (rst) mon_en = 1'b1;
    endtask

    task automatic drive(input logic r, input logic st, input logic [3:0] d);
        @(negedge clk);
        rst   = r;
        start = st;
        din   = d;
        @(posedge clk);
        model_step();
    endtask

    task automatic cmp(input string nm, input int i, input int act, input int exp);
        vecs++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s inst%0d cyc%0d got %0h want %0h", nm, i, cyc, act, exp);
        end
    endtask

    // Monitor: per-cycle timing checks, plus scoreboard pop on every DONE.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                for (int i = 0; i < 2; i++) begin
                    int         k, h, n;
                    logic       e_bz, e_dn;
                    logic [1:0] e_sel;
                    logic [3:0] e_res, fin, a_dw, a_res, exp_w;
                    logic [1:0] a_sel;
                    logic       a_bz, a_dn;
                    h     = hc[i];
                    fin   = CAP ? lat[i] : 4'h0;
                    e_bz  = 1'b0;
                    e_dn  = 1'b0;
                    e_sel = 2'd0;
                    e_res = (s_at[i] < 0) ? 4'h0 : fin;
                    if (s_at[i] >= 0) begin
                        k = cyc - s_at[i];
                        if (k < 4 * h) begin
                            n     = k / h;
                            e_bz  = 1'b1;
                            e_sel = 2'(n);
                            e_res = CAP ? (lat[i] & ~(4'hF >> n)) : 4'h0;
                        end else if (k == 4 * h) begin
                            e_dn = 1'b1;
                        end
                    end
                    if (i == 0) begin
                        a_sel = {a0, b0}; a_dw = {d00, d01, d02, d03};
                        a_res = r0; a_bz = bz0; a_dn = dn0;
                    end else begin
                        a_sel = {a1, b1}; a_dw = {d10, d11, d12, d13};
                        a_res = r1; a_bz = bz1; a_dn = dn1;
                    end
                    cmp("busy", i, int'(a_bz), int'(e_bz));
                    cmp("done", i, int'(a_dn), int'(e_dn));
                    cmp("sel", i, int'(a_sel), int'(e_sel));
                    cmp("data", i, int'(a_dw), int'(lat[i]));
                    cmp("result", i, int'(a_res), int'(e_res));
                    if (a_dn) begin
                        if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                            cmp("sb_empty", i, 1, 0);
                        end else begin
                            exp_w = (i == 0) ? q0.pop_front() : q1.pop_front();
                            cmp("sb_result", i, int'(a_res), CAP ? int'(exp_w) : 0);
                            cmp("sb_data", i, int'(a_dw), int'(exp_w));
                        end
                    end
                end
            end
        end
    end

    // Stimulus: directed sweeps first, then randomized traffic.
    initial begin
        for (int j = 0; j < 3; j++) drive(1'b1, 1'b1, 4'hF);
        for (int j = 0; j < 3; j++) drive(1'b0, 1'b0, 4'h0);
        drive(1'b0, 1'b1, 4'b1010);
        for (int j = 0; j < 48; j++) drive(1'b0, 1'b0, 4'b1010);
        drive(1'b0, 1'b1, 4'b0110);
        for (int j = 0; j < 12; j++) drive(1'b0, 1'b0, 4'b1111);
        drive(1'b0, 1'b1, 4'b1111);
        for (int j = 0; j < 40; j++) drive(1'b0, 1'b0, 4'b1111);
        drive(1'b0, 1'b1, 4'b1010);
        for (int j = 0; j < 24; j++) drive(1'b0, 1'b0, 4'b1010);
        drive(1'b1, 1'b1, 4'b1010);
        for (int j = 0; j < 4; j++) drive(1'b0, 1'b0, 4'b0000);
        for (int j = 0; j < 60; j++) drive(1'b0, 1'b1, 4'b0001);
        for (int j = 0; j < 50; j++) drive(1'b0, 1'b0, 4'b0000);
        for (int j = 0; j < 3000; j++) begin
            logic       r, st;
            logic [3:0] d;
            r  = ($urandom_range(0, 299) == 0);
            st = ($urandom_range(0, 3) == 0);
            d  = 4'($urandom);
            drive(r, st, d);
        end
        for (int j = 0; j < 60; j++) drive(1'b0, 1'b0, 4'h0);
        @(negedge clk);
        cmp("sb_drain0", 0, q0.size(), 0);
        cmp("sb_drain1", 1, q1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/mux_sel_sequencer.md
MUX_SEL_SEQUENCER -- requirements
Module: mux_sel_sequencer

Interface
REQ-001 SHALL have parameter: HOLD_CYCLES, default 10, cycles each select value is held (legal range 1..255).
REQ-002 SHALL have port: CLK  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: RST  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: START  input  1  sweep request, sampled only in IDLE.
REQ-005 SHALL have port: DATA_IN  input  4  data word to present to the 4:1 mux.
REQ-006 SHALL have ports: A, B  output  1 each  mux select, A is MSB ({A,B} = sel).
REQ-007 SHALL have ports: D0, D1, D2, D3  output  1 each  mux data, {D0,D1,D2,D3} = latched DATA_IN.
REQ-008 SHALL have port: Y_IN  input  1  mux output fed back for capture.
REQ-009 SHALL have port: RESULT  output  4  captured Y_IN word.
REQ-010 SHALL have ports: BUSY, DONE  output  1 each  sweep in progress / one-cycle completion pulse.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, FIN; IDLE after reset.
REQ-012 In IDLE with START=1: latch DATA_IN into D0..D3, set sel=0, clear hold counter, clear RESULT, go to RUN; BUSY=1 from next cycle.
REQ-013 In RUN: hold sel for exactly HOLD_CYCLES cycles, then increment sel; after sel=3 has been held HOLD_CYCLES cycles, go to FIN.
REQ-014 BUSY SHALL be 1 for exactly 4*HOLD_CYCLES cycles per sweep.
REQ-015 FIN SHALL last one cycle with DONE=1, BUSY=0, then return to IDLE; DONE SHALL be 0 in all other states.
REQ-016 Capture: on the last hold cycle of select value i, RESULT[3-i] SHALL load Y_IN, so an ideal mux yields RESULT == DATA_IN.
REQ-017 D0..D3 SHALL remain constant during RUN regardless of DATA_IN changes, and hold their value in IDLE until the next START.
REQ-018 {A,B} SHALL return to 2'b00 on entering FIN and stay 00 in IDLE.
REQ-019 START while in RUN or FIN SHALL be ignored (no restart, no queueing).
REQ-020 START held high continuously SHALL start a new sweep on the first IDLE cycle after FIN.
REQ-021 HOLD_CYCLES=1 SHALL give one cycle per select value, BUSY high 4 cycles.
REQ-022 RESULT SHALL remain stable from FIN until the next accepted START.

Reset
REQ-023 RST=1 at a clock edge SHALL force IDLE and A=B=0, D0..D3=0, RESULT=0, BUSY=0, DONE=0, hold counter=0, in any state including mid-sweep.
REQ-024 RST SHALL take priority over START in the same cycle; the first START sampled is the one after RST is released.

Configuration
REQ-025 Macro SEQ_CAPTURE_EN defined: capture per REQ-016 active.
REQ-026 Macro SEQ_CAPTURE_EN undefined: Y_IN ignored, RESULT tied to 4'b0000, ports remain present, all other behaviour unchanged.

Verification
REQ-027 Reset mid-sweep: START, DATA_IN=4'b1010, assert RST during sel=2 -> next cycle all outputs 0, IDLE, no DONE pulse.
REQ-028 Full sweep with funcao_1 in loop, HOLD_CYCLES=10, DATA_IN=4'b1010 -> {A,B}=00,01,10,11 each 10 cycles, Y=1,0,1,0, BUSY 40 cycles, DONE one cycle, RESULT=4'b1010.
REQ-029 DATA_IN=4'b0110 changed to 4'b1111 during RUN -> D0..D3 stay 0,1,1,0, RESULT=4'b0110.
REQ-030 START pulsed again at sel=1 -> ignored, exactly one DONE pulse after 4*HOLD_CYCLES cycles.
REQ-031 HOLD_CYCLES=1, START held high, DATA_IN=4'b0001 -> back-to-back sweeps, BUSY 4 cycles, DONE, one IDLE cycle, restart; RESULT=4'b0001 each sweep.
REQ-032 SEQ_CAPTURE_EN undefined, DATA_IN=4'b1010 sweep -> RESULT stays 4'b0000, select/data/DONE timing identical to REQ-028.
